ieee754_divider: RTL and testbench

Sequential IEEE-754 binary32 divider computing result = input_a / input_b. It is the inverse-operation companion to the team's combinational binary32 multiplier and uses the same conventions: implicit leading 1, truncation rounding, and no denormal support. The datapath is a radix-2 restoring mantissa divider that produces one quotient bit per cycle. Operands and results move over valid/ready handshakes, so the block can sit directly in the FP datapath pipeline.

---
 rtl/ieee754_divider.sv | 143 ++++++++++++++
 tb/tb_ieee754_divider.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee754_divider.sv
// Sequential binary32 divider: radix-2 restoring mantissa division, one quotient
// bit per cycle, truncation rounding, no denormals, valid/ready on both sides.
module ieee754_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORMALIZE, DONE} state_t;

  state_t state, next_state;

  logic        sign;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] mb;
  logic [24:0] rem;
  logic [24:0] quot;
  logic [4:0]  bit_cnt;

  logic               accept;
  logic               is_special;
  logic               rem_ge;
  logic [24:0]        rem_sub;
  logic [24:0]        rem_shift;
  logic signed [9:0]  exp_calc;
  logic [22:0]        mant;
  logic [31:0]        special_result;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Zero exponent fields short-circuit the division on the first DIVIDE cycle.
  assign is_special = (ea == 8'd0) || (eb == 8'd0);

  always_comb begin
    special_result = {sign, 31'd0};
    if (eb == 8'd0) begin
      if (ea == 8'd0) special_result = 32'h7FC0_0000;
      else            special_result = {sign, 8'hFF, 23'd0};
    end
  end

  // One restoring step: the remainder after subtraction is always below mb,
  // so the left shift never loses a significant bit.
  assign rem_ge    = (rem >= {1'b0, mb});
  assign rem_sub   = rem_ge ? (rem - {1'b0, mb}) : rem;
  assign rem_shift = rem_sub << 1;

  assign exp_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126
                    + $signed({9'd0, quot[24]});
  assign mant     = quot[24] ? quot[23:1] : quot[22:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = DIVIDE;
      DIVIDE: begin
        if (is_special)            next_state = DONE;
        else if (bit_cnt == 5'd0)  next_state = NORMALIZE;
      end
      NORMALIZE: next_state = DONE;
      DONE:      if (out_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign        <= 1'b0;
      ea          <= 8'd0;
      eb          <= 8'd0;
      mb          <= 24'd0;
      rem         <= 25'd0;
      quot        <= 25'd0;
      bit_cnt     <= 5'd0;
      out_valid   <= 1'b0;
      result      <= 32'd0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign        <= input_a[31] ^ input_b[31];
            ea          <= input_a[30:23];
            eb          <= input_b[30:23];
            mb          <= {1'b1, input_b[22:0]};
            rem         <= {2'b01, input_a[22:0]};
            quot        <= 25'd0;
            bit_cnt     <= 5'd24;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
          end
        end
        DIVIDE: begin
          if (is_special) begin
            result      <= special_result;
            div_by_zero <= (eb == 8'd0);
            out_valid   <= 1'b1;
          end else begin
            quot    <= {quot[23:0], rem_ge};
            rem     <= rem_shift;
            bit_cnt <= bit_cnt - 5'd1;
          end
        end
        NORMALIZE: begin
          out_valid <= 1'b1;
          if (exp_calc >= 10'sd255) begin
            result   <= {sign, 8'hFF, 23'd0};
            overflow <= 1'b1;
          end else if (exp_calc <= 10'sd0) begin
            result    <= {sign, 31'd0};
            underflow <= 1'b1;
          end else begin
            result <= {sign, exp_calc[7:0], mant};
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ieee754_divider.sv
// Testbench for ieee754_divider: directed vector table, backpressure and
// mid-operation reset sequences, and randomized operands against a reference model.
module tb_ieee754_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] input_a = 32'd0;
  logic [31:0] input_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        div_by_zero;
  logic        overflow;
  logic        underflow;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  ieee754_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_a     (input_a),
    .input_b     (input_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Reference model: straight arithmetic on the decoded fields.
  function automatic vec_t refDiv(input logic [31:0] a, input logic [31:0] b);
    vec_t            v;
    int              ea, eb, e;
    longint unsigned ma, mb, q;
    logic            s;
    logic [22:0]     m;
    v.a = a; v.b = b; v.dbz = 1'b0; v.ovf = 1'b0; v.unf = 1'b0;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = 64'h80_0000 | 64'(a[22:0]);
    mb = 64'h80_0000 | 64'(b[22:0]);
    if (eb == 0) begin
      v.dbz = 1'b1;
      v.lat = 1;
      v.res = (ea == 0) ? 32'h7FC0_0000 : {s, 8'hFF, 23'd0};
    end else if (ea == 0) begin
      v.lat = 1;
      v.res = {s, 31'd0};
    end else begin
      v.lat = 26;
      q = (ma << 24) / mb;
      if (q >= 64'h100_0000) begin
        e = ea - eb + 127;
        m = 23'((q >> 1) & 64'h7F_FFFF);
      end else begin
        e = ea - eb + 126;
        m = 23'(q & 64'h7F_FFFF);
      end
      if (e >= 255) begin
        v.ovf = 1'b1;
        v.res = {s, 8'hFF, 23'd0};
      end else if (e <= 0) begin
        v.unf = 1'b1;
        v.res = {s, 31'd0};
      end else begin
        v.res = {s, 8'(e), m};
      end
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Presents operands at a negedge once the block is ready, then counts
  // rising edges from the accept until out_valid appears (bounded).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    input_a  = a;
    input_b  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    input_a  = $urandom;
    input_b  = $urandom;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int lat;
    applyStimulus(v.a, v.b, lat);
    checkOutput({tag, " result"}, result, v.res);
    checkOutput({tag, " flags"}, {29'd0, div_by_zero, overflow, underflow},
                {29'd0, v.dbz, v.ovf, v.unf});
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    int          seen;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 26};
    vecs[1] = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0, 1'b0, 26};
    vecs[2] = '{32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, 1'b0, 1'b0, 1'b0, 26};
    vecs[3] = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[6] = '{32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 1'b1, 1'b0, 26};
    vecs[7] = '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 26};

    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset flags", {29'd0, div_by_zero, overflow, underflow}, 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: stall the consumer while a second request waits.
    out_ready = 1'b0;
    applyStimulus(32'h40C0_0000, 32'h4000_0000, lat);
    checkOutput("bp latency", 32'(lat), 32'd26);
    checkOutput("bp result", result, 32'h4040_0000);
    input_a  = 32'h3F80_0000;
    input_b  = 32'h4040_0000;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp hold out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp hold result", result, 32'h4040_0000);
      checkOutput("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp handshake out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp handshake in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("bp accept in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    input_a  = $urandom;
    input_b  = $urandom;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("bp second latency", 32'(lat), 32'd26);
    checkOutput("bp second result", result, 32'h3EAA_AAAA);
    @(posedge clk);
    #1;

    // Reset in the middle of DIVIDE.
    @(negedge clk);
    input_a  = 32'h40C0_0000;
    input_b  = 32'h4000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst result", result, 32'd0);
    checkOutput("midrst flags", {29'd0, div_by_zero, overflow, underflow}, 32'd0);
    checkOutput("midrst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    checkOutput("midrst no out_valid", 32'(seen), 32'd0);
    runVector(vecs[0], "post-reset");

    // Randomized operands, biased towards in-range exponents and zero fields.
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end
      if ($urandom_range(0, 9) == 0) ra[30:23] = 8'd0;
      if ($urandom_range(0, 9) == 0) rb[30:23] = 8'd0;
      runVector(refDiv(ra, rb), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
